// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
//   ctrl_state_e   : controller FSM state (running / waiting on data memory)
//   REG_ADDR_WIDTH : architectural register index width
//   CNT_WIDTH      : width of the performance counters
package pipeline_ctrl_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CNT_WIDTH      = 32;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } ctrl_state_e;
endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the controller's performance counters.
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   inc_i      : count this cycle
//   cnt_o      : current count, holds at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline. Produces pipeline
// register load enables and bubble (flush) controls combinationally from the
// current FSM state and stage inputs, with priority
// memory wait > redirect > load-use > normal.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ID_*                : source registers / usage of the instruction in ID
//   EX_*                : load flag, destination, taken-branch of EX instr
//   MEM_Mem*, dmem_ready_i : data memory access and its completion
//   *_en_o / *_flush_o  : pipeline register enables / bubble inserts
//   mem_timeout_o       : sticky flag, memory wait exceeded MEM_TIMEOUT
//   stall_cnt_o         : cycles with PC_en_o=0
//   flush_cnt_o         : cycles with IF_ID_flush_o=1 (redirects)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rs2_addr_i,
  input  logic                      ID_use_rs1_i,
  input  logic                      ID_use_rs2_i,
  input  logic                      EX_MemRead_i,
  input  logic [REG_ADDR_WIDTH-1:0] EX_rd_addr_i,
  input  logic                      EX_branch_taken_i,
  input  logic                      MEM_MemRead_i,
  input  logic                      MEM_MemWrite_i,
  input  logic                      dmem_ready_i,
  output logic                      PC_en_o,
  output logic                      IF_ID_en_o,
  output logic                      ID_EX_en_o,
  output logic                      EX_MEM_en_o,
  output logic                      MEM_WB_en_o,
  output logic                      IF_ID_flush_o,
  output logic                      ID_EX_flush_o,
  output logic                      MEM_WB_flush_o,
  output logic                      mem_timeout_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);
  // Wide enough to hold MEM_TIMEOUT (and non-zero width when it is 0).
  localparam int              WAIT_W  = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic mem_busy, load_use, frozen;

  assign mem_busy = (MEM_MemRead_i | MEM_MemWrite_i) & ~dmem_ready_i;

  assign load_use = EX_MemRead_i && (EX_rd_addr_i != '0) &&
                    ((ID_use_rs1_i && (ID_rs1_addr_i == EX_rd_addr_i)) ||
                     (ID_use_rs2_i && (ID_rs2_addr_i == EX_rd_addr_i)));

  // Once waiting, only dmem_ready_i releases the freeze; the access inputs
  // are not re-sampled. A redirect or load-use held in EX/ID during the
  // freeze is simply re-evaluated on the release cycle.
  assign frozen = (state_q == S_MEM_WAIT) ? ~dmem_ready_i : mem_busy;

  always_comb begin
    PC_en_o        = 1'b1;
    IF_ID_en_o     = 1'b1;
    ID_EX_en_o     = 1'b1;
    EX_MEM_en_o    = 1'b1;
    MEM_WB_en_o    = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_flush_o  = 1'b0;
    MEM_WB_flush_o = 1'b0;
    if (!rst_n) begin
      PC_en_o     = 1'b0;
      IF_ID_en_o  = 1'b0;
      ID_EX_en_o  = 1'b0;
      EX_MEM_en_o = 1'b0;
      MEM_WB_en_o = 1'b0;
    end else if (frozen) begin
      // Everything up to MEM holds; WB gets a bubble so the stalled MEM
      // instruction is not retired twice.
      PC_en_o        = 1'b0;
      IF_ID_en_o     = 1'b0;
      ID_EX_en_o     = 1'b0;
      EX_MEM_en_o    = 1'b0;
      MEM_WB_flush_o = 1'b1;
    end else if (EX_branch_taken_i) begin
      IF_ID_flush_o = 1'b1;
      ID_EX_flush_o = 1'b1;
    end else if (load_use) begin
      PC_en_o       = 1'b0;
      IF_ID_en_o    = 1'b0;
      ID_EX_flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d    = frozen ? S_MEM_WAIT : S_RUN;
    wait_cnt_d = '0;
    if (state_q == S_MEM_WAIT)
      wait_cnt_d = (wait_cnt_q == TO_VAL) ? wait_cnt_q : wait_cnt_q + 1'b1;
    timeout_d = timeout_q | ((state_q == S_MEM_WAIT) && (wait_cnt_d >= TO_VAL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout_o = timeout_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (rst_n & ~PC_en_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (rst_n & IF_ID_flush_o),
    .cnt_o (flush_cnt_o)
  );
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max consecutive MEM_WAIT cycles before the timeout flag sets.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- ID_rs1_addr_i / ID_rs2_addr_i  in  5 each  source registers of the instruction in ID
- ID_use_rs1_i / ID_use_rs2_i  in  1 each  ID instruction reads rs1 / rs2
- EX_MemRead_i  in  1  EX instruction is a load
- EX_rd_addr_i  in  5  EX destination register
- EX_branch_taken_i  in  1  EX resolves a taken branch or jump (PC redirect)
- MEM_MemRead_i / MEM_MemWrite_i  in  1 each  MEM stage data-memory access
- dmem_ready_i  in  1  data memory completes the current access this cycle
- PC_en_o, IF_ID_en_o, ID_EX_en_o, EX_MEM_en_o, MEM_WB_en_o  out  1 each  pipeline-register load enables
- IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o  out  1 each  load a bubble (all-zero control) instead of data
- mem_timeout_o  out  1  sticky error flag
- stall_cnt_o  out  32  cycles with PC_en_o=0
- flush_cnt_o  out  32  redirect events

Function
REQ-003 SHALL implement FSM states S_RUN and S_MEM_WAIT (ctrl_state_e).
REQ-004 SHALL derive enables/flushes combinationally from state and inputs (Mealy), with no added latency.
REQ-005 SHALL define mem_busy = (MEM_MemRead_i | MEM_MemWrite_i) & ~dmem_ready_i.
REQ-006 S_RUN with mem_busy: PC/IF_ID/ID_EX/EX_MEM enables 0; MEM_WB_en_o=1; MEM_WB_flush_o=1; other flushes 0; next state S_MEM_WAIT.
REQ-007 S_MEM_WAIT: same outputs as REQ-006 while dmem_ready_i=0; when dmem_ready_i=1, outputs follow the S_RUN rules without mem_busy, and next state is S_RUN.
REQ-008 Redirect (EX_branch_taken_i=1, no mem_busy): all enables 1; IF_ID_flush_o=1; ID_EX_flush_o=1.
REQ-009 Load-use = EX_MemRead_i & (EX_rd_addr_i!=0) & ((ID_use_rs1_i & rs1==rd) | (ID_use_rs2_i & rs2==rd)).
REQ-010 Load-use (no mem_busy, no redirect): PC_en_o=0; IF_ID_en_o=0; ID_EX_en_o=1 with ID_EX_flush_o=1; EX_MEM/MEM_WB enables 1.
REQ-011 Priority SHALL be mem_busy > redirect > load-use > normal. Normal: all enables 1, all flushes 0.
REQ-012 A redirect held during S_MEM_WAIT SHALL NOT be lost: EX is frozen, the input persists, and it takes effect on the release cycle.
REQ-013 SHALL count consecutive S_MEM_WAIT cycles. When the count reaches MEM_TIMEOUT, mem_timeout_o SHALL set and stay 1 until reset. The wait count SHALL clear on entry to S_RUN.
REQ-014 stall_cnt_o SHALL increment each cycle PC_en_o=0. flush_cnt_o SHALL increment each cycle IF_ID_flush_o=1. Both saturate at 32'hFFFF_FFFF.

Reset
REQ-015 While rst_n=0: state=S_RUN; all enables 0; all flushes 0; mem_timeout_o=0; stall_cnt_o=0; flush_cnt_o=0; wait count 0.
REQ-016 Reset asserted mid-S_MEM_WAIT SHALL abort the wait immediately (asynchronous). The first cycle after release evaluates S_RUN rules.
REQ-017 While rst_n=0, counters SHALL NOT count the forced-zero enables.

Structure
REQ-018 Package defines SHALL hold ctrl_state_e {S_RUN, S_MEM_WAIT}, REG_ADDR_WIDTH=5, and CNT_WIDTH=32.
REQ-019 SHALL instantiate sub-module sat_counter (width parameter; ports clk, rst_n, inc_i, cnt_o) twice, for stall_cnt_o and flush_cnt_o.

Verification
REQ-020 Load-use: EX_MemRead_i=1, EX_rd=5, ID_rs1=5, ID_use_rs1_i=1 for one cycle -> PC_en_o=0, IF_ID_en_o=0, ID_EX_flush_o=1 that cycle; stall_cnt_o=1 afterwards. Repeat with EX_rd=0 -> no stall.
REQ-021 Redirect: EX_branch_taken_i=1 for one cycle -> IF_ID_flush_o=ID_EX_flush_o=1, PC_en_o=1; flush_cnt_o increments 0->1.
REQ-022 Memory wait: MEM_MemRead_i=1, dmem_ready_i=0 for 3 cycles, then 1 -> 3 frozen cycles with MEM_WB_flush_o=1; release cycle all enables 1; state back to S_RUN; stall_cnt_o=3.
REQ-023 Simultaneous events: mem_busy + redirect + load-use asserted together -> mem-wait outputs only; after dmem_ready_i=1, redirect flush applies on the release cycle.
REQ-024 Timeout: MEM_TIMEOUT=4, dmem_ready_i held 0 -> mem_timeout_o rises after 4 wait cycles and stays 1 after dmem_ready_i=1; clears only on rst_n=0.
REQ-025 Reset mid-wait: rst_n=0 in the 2nd S_MEM_WAIT cycle -> outputs and counters zero immediately; after release with no hazards, all enables 1.
